uart_tx: RTL and testbench

//  Serial UART transmitter; companion to the team's falling-edge start detector on the receive side.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and sizing helpers used by the TX and RX paths.
// The TX parity stage is built only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Bits needed to hold 0..value-1; never less than 1 so it is always a legal width.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and strobes bit_done on the last count.
// A synchronous clear holds it at zero so every frame starts aligned to acceptance.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter with a valid/ready byte interface; txd idles high.
// Define UART_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              busy,
    output logic              txd,
    output tx_state_t         state
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W = clog2(DATA_W);

    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (CPB < 2 || DATA_W < 5 || DATA_W > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_config
        $error("uart_tx: unsupported parameter combination");
    end

    // Handshake: a byte is taken on a rising clk edge where tx_valid && tx_ready; tx_ready is
    // high only in IDLE, so a request made while a frame is running is dropped, never queued.
    logic              accept;
    logic              bit_done;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
`ifdef UART_PARITY_EN
    logic              par_bit;
`endif

    assign accept = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (state == IDLE),
        .bit_done(bit_done)
    );

    // bit_idx counts data bits in DATA and is reused to count stop bits in STOP.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
`ifdef UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= START;
                        txd      <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        shreg    <= tx_data;
                        bit_idx  <= '0;
`ifdef UART_PARITY_EN
                        par_bit  <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[DATA_W-1:1]};
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_PARITY_EN
                            state   <= PARITY;
                            txd     <= par_bit;
`else
                            state   <= STOP;
                            txd     <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_W-1:1]};
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_STOP) begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            bit_idx  <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; frame timing follows UART_PARITY_EN.
module tb_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int CPB       = 10;
    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;
`ifdef UART_PARITY_EN
    localparam int NBITS = 1 + DATA_W + 1 + STOP_BITS;
`else
    localparam int NBITS = 1 + DATA_W + STOP_BITS;
`endif
    localparam int FRAME = NBITS * CPB;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              busy;
    logic              txd;
    uart_pkg::tx_state_t state;

    int   checks   = 0;
    int   failures = 0;
    int   falls    = 0;
    int   falls0;
    logic txd_q    = 1'b1;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_W    (DATA_W),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(0)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .busy    (busy),
        .txd     (txd),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Falling-edge counter standing in for the receiver's start detector.
    always @(posedge clk) begin
        txd_q <= txd;
        if (txd_q === 1'b1 && txd === 1'b0) falls <= falls + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int c);
        int idx;
        idx = (c - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DATA_W) return d[idx-1];
`ifdef UART_PARITY_EN
        if (idx == DATA_W + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called just after the accepting edge; walks the frame and the first IDLE cycle after it.
    task automatic check_frame(input logic [7:0] d, input string tag, input int inject_at,
                               input bit scramble);
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            chk($sformatf("%s_txd_c%0d", tag, c), 32'(txd), 32'(exp_bit(d, c)));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
            chk($sformatf("%s_ready_c%0d", tag, c), 32'(tx_ready), 32'd0);
            if (scramble && c == 25) tx_data = ~d;
            if (inject_at != 0 && c == inject_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (inject_at != 0 && c == inject_at + 20) tx_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_ready_end"}, 32'(tx_ready), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_txd_end"}, 32'(txd), 32'd1);
        chk({tag, "_state_end"}, 32'(state), 32'(uart_pkg::ST_IDLE));
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        n_rst    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state), 32'(uart_pkg::ST_IDLE));
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_txd", 32'(txd), 32'd1);
            chk("idle_ready", 32'(tx_ready), 32'd1);
        end

        // Single byte, tx_data changed after acceptance.
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        tx_data = 8'h00;
        check_frame(8'hA5, "a5", 0, 1'b1);

        // Back-to-back with tx_valid held: second start must follow 101 cycles after the first.
        falls0   = falls;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        check_frame(8'h00, "b2b_00", 0, 1'b0);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(8'hFF, "b2b_ff", 0, 1'b0);
        chk("b2b_start_edges", 32'(falls - falls0), 32'd2);

        // Request during a busy frame is ignored and not sent afterwards.
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(8'h5A, "busy_ign", 40, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("busy_ign_after_txd", 32'(txd), 32'd1);
            chk("busy_ign_after_state", 32'(state), 32'(uart_pkg::ST_IDLE));
        end

        // Asynchronous reset during data bit 3, then a clean frame.
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (44) @(negedge clk);
        chk("mid_pre_txd", 32'(txd), 32'd0);
        chk("mid_pre_state", 32'(state), 32'(uart_pkg::ST_DATA));
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        chk("mid_rst_state", 32'(state), 32'(uart_pkg::ST_IDLE));
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mid_post_txd", 32'(txd), 32'd1);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(8'h55, "after_rst_55", 0, 1'b0);

        // 8'h07: parity bit 1 and 111-cycle frame when parity is built, 101 cycles otherwise.
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(8'h07, "par_07", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
